// File: rtl/aes_pkg.sv
// Shared AES packer definitions: widths, FSM states
// and the PKCS#7 fill-byte helper.
package aes_pkg;

   localparam int AES_BLK_W  = 128;
   localparam int AES_WORD_W = 32;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_OUT,
      ST_PADOUT
   } state_t;

   // Value of block byte idx when the message ends with n
   // valid bytes: data bytes read as 0, pad bytes as 16-n.
   function automatic logic [7:0] pkcs7_fill(
      input logic [3:0] idx,
      input logic [4:0] n
   );
      logic [4:0] pad;
      pad = 5'd16 - n;
      if ({1'b0, idx} < n)
         return 8'h00;
      return {3'b000, pad};
   endfunction

endpackage

// File: rtl/aes_block_packer.sv
// Packs 32-bit words into 128-bit AES blocks with
// optional PKCS#7 padding of the final block.
module aes_block_packer
   import aes_pkg::*;
#(
   parameter bit PAD_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [AES_WORD_W-1:0] s_data,
   input  logic                  s_last,
   input  logic [2:0]            s_bytes,
   input  logic                  mode,
   output logic                  blk_valid,
   input  logic                  blk_ready,
   output logic [AES_BLK_W-1:0]  blk_data,
   output logic                  blk_mode,
   output logic                  blk_last,
   output logic                  err
);

   state_t               state;
   state_t               state_nxt;
   logic [1:0]           word_idx;
   logic                 pad_pend;
   logic                 rdy_en;

   logic                 acc;
   logic                 blk_done;
   logic                 bytes_bad;
   logic [2:0]           nb_eff;
   logic [4:0]           n;
   logic                 cur_mode;
   logic                 use_pad;
   logic                 full_pad;
   logic                 err_set;
   logic [AES_BLK_W-1:0] blk_nxt;
   logic [7:0]           pad_byte;

   assign s_ready   = (state == ST_FILL) && rdy_en;
   assign blk_valid = (state == ST_OUT) ||
                      (state == ST_PADOUT);
   assign acc       = s_valid && s_ready;

   // Decode the incoming word: byte count, fill length, errors.
   always_comb begin
      bytes_bad = s_last &&
                  ((s_bytes == 3'd0) || (s_bytes > 3'd4));
      nb_eff    = bytes_bad ? 3'd4 : s_bytes;
      n         = {1'b0, word_idx, 2'b00} +
                  {2'b00, nb_eff};
      cur_mode  = (word_idx == 2'd0) ? mode : blk_mode;
      use_pad   = cur_mode && PAD_EN;
      blk_done  = acc && (s_last || (word_idx == 2'd3));
      full_pad  = s_last && use_pad && (n == 5'd16);
      err_set   = acc && s_last &&
                  (bytes_bad || ((n < 5'd16) && !use_pad));
   end

   // Merge the word into its slot; on a final word fill the tail.
   always_comb begin
      blk_nxt  = blk_data;
      pad_byte = 8'h00;
      for (int i = 0; i < 16; i++) begin
         pad_byte = use_pad ? pkcs7_fill(i[3:0], n) : 8'h00;
         if (i[3:2] == word_idx) begin
            if (!s_last || ({1'b0, i[1:0]} < nb_eff))
               blk_nxt[127-8*i -: 8] = s_data[31-8*i[1:0] -: 8];
            else
               blk_nxt[127-8*i -: 8] = pad_byte;
         end else if ((i[3:2] > word_idx) && s_last) begin
            blk_nxt[127-8*i -: 8] = pad_byte;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         state <= ST_FILL;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_FILL: begin
            if (blk_done)
               state_nxt = ST_OUT;
         end
         ST_OUT: begin
            if (blk_ready)
               state_nxt = pad_pend ? ST_PADOUT : ST_FILL;
         end
         ST_PADOUT: begin
            if (blk_ready)
               state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   // Block register, word counter, flags and sticky error.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rdy_en   <= 1'b0;
         word_idx <= 2'd0;
         pad_pend <= 1'b0;
         blk_data <= '0;
         blk_mode <= 1'b0;
         blk_last <= 1'b0;
         err      <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         err    <= err | err_set;
         if (acc) begin
            blk_data <= blk_nxt;
            word_idx <= blk_done ? 2'd0 : word_idx + 2'd1;
            if (word_idx == 2'd0)
               blk_mode <= mode;
         end
         if (blk_done) begin
            blk_last <= s_last && !full_pad;
            pad_pend <= full_pad;
         end
         if ((state == ST_OUT) && blk_ready && pad_pend) begin
            blk_data <= {16{8'h10}};
            blk_last <= 1'b1;
            pad_pend <= 1'b0;
         end
      end
   end

endmodule
